// File: rtl/audio_key_scheduler_if.sv
// audio_key_scheduler_if
//  Groups the key inputs and audio/status outputs of the front-panel tone scheduler.
//  master: drives btn/enable and observes the outputs (board glue or testbench).
//  slave : the scheduler itself.
//  btn       8  raw keys, active low, asynchronous to clk
//  enable    1  1 = tones allowed
//  pwmout    1  square-wave audio output
//  led       6  debounced pressed state of keys 5..0, active high
//  key_valid 1  high while a tone is playing
//  key_idx   3  index of the key currently sounding
interface audio_key_scheduler_if;
  logic [7:0] btn;
  logic       enable;
  logic       pwmout;
  logic [5:0] led;
  logic       key_valid;
  logic [2:0] key_idx;

  modport master (
    output btn, enable,
    input  pwmout, led, key_valid, key_idx
  );

  modport slave (
    input  btn, enable,
    output pwmout, led, key_valid, key_idx
  );
endinterface

// File: rtl/audio_key_scheduler.sv
// audio_key_scheduler
//  Arbitrates eight front-panel keys for one square-wave audio output.
//  Each key is synchronised and debounced; the highest pressed index wins.
//  The tone generator only changes pitch or stops on half-period edges, so
//  every pwmout pulse is a whole half-period of the key that owned it.
// Ports
//  clk    system clock
//  rst_n  asynchronous reset, active low
//  bus    audio_key_scheduler_if.slave (btn, enable in; pwmout, led, key_valid, key_idx out)
// Parameters
//  BASE_LOG2        key k half-period = 2**(BASE_LOG2+k) clk
//  DEBOUNCE_CYCLES  stable synced samples needed to accept a key change (>=1)
module audio_key_scheduler #(
  parameter int BASE_LOG2       = 9,
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  audio_key_scheduler_if.slave  bus
);

  localparam int CNT_W = BASE_LOG2 + 8;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [7:0]      sync1, sync2;
  logic [7:0]      deb, deb_next;
  logic [DB_W-1:0] db_cnt      [8];
  logic [DB_W-1:0] db_cnt_next [8];
  logic [5:0]      led_q;

  logic [7:0]      pressed;
  logic            win_valid;
  logic [2:0]      win_idx;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic            half_edge;
  logic            pwm_q;
  logic            kv_q;
  logic [2:0]      idx_q;

  // The counter only advances while the synced level disagrees with the
  // accepted level. The flip happens on the sample after the count reaches
  // DEBOUNCE_CYCLES, giving a press-to-debounced latency of 2 + DEBOUNCE_CYCLES.
  always_comb begin
    deb_next = deb;
    for (int k = 0; k < 8; k++) begin
      db_cnt_next[k] = '0;
      if (sync2[k] != deb[k]) begin
        if (db_cnt[k] == DB_MAX) begin
          deb_next[k] = ~deb[k];
        end else begin
          db_cnt_next[k] = db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Synchronisers and debounced state reset to "released" (keys are active low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      led_q <= '0;
      for (int k = 0; k < 8; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync1  <= bus.btn;
      sync2  <= sync1;
      deb    <= deb_next;
      led_q  <= ~deb_next[5:0];
      db_cnt <= db_cnt_next;
    end
  end

  assign pressed   = ~deb;
  assign win_valid = (|pressed) & bus.enable;

  // Ascending scan, so the highest pressed index overwrites lower ones.
  always_comb begin
    win_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pressed[k]) begin
        win_idx = 3'(k);
      end
    end
  end

  assign half_m1   = (CNT_W'(1) << (BASE_LOG2 + int'(idx_q))) - CNT_W'(1);
  assign half_edge = (cnt == half_m1);

  // Pitch, stop and start decisions are only taken on IDLE entry or on a
  // half-period edge; between edges the tone runs on untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pwm_q <= 1'b0;
      kv_q  <= 1'b0;
      idx_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          pwm_q <= 1'b0;
          kv_q  <= 1'b0;
          if (win_valid) begin
            state <= PLAY;
            idx_q <= win_idx;
            pwm_q <= 1'b1;
            kv_q  <= 1'b1;
          end
        end
        PLAY: begin
          if (!half_edge) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!win_valid) begin
              state <= IDLE;
              pwm_q <= 1'b0;
              kv_q  <= 1'b0;
            end else begin
              pwm_q <= ~pwm_q;
              idx_q <= win_idx;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pwm_q <= 1'b0;
          kv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwmout    = pwm_q;
  assign bus.led       = led_q;
  assign bus.key_valid = kv_q;
  assign bus.key_idx   = idx_q;

endmodule

// File: tb/tb_audio_key_scheduler.sv
// tb_audio_key_scheduler
//  Self-checking bench for audio_key_scheduler with BASE_LOG2=2, DEBOUNCE_CYCLES=4.
//  Expected half-periods (level, length, key index) are queued when a key
//  scenario is set up and popped as the DUT produces each half-period.
module tb_audio_key_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  audio_key_scheduler_if bus ();

  audio_key_scheduler #(
    .BASE_LOG2       (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       lvl;
    int         len;
    logic [2:0] idx;
  } half_t;

  half_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Observes one half-period that starts at the current negedge; returns at
  // the first negedge of the following half (bounded).
  task automatic measure_half(output logic lvl, output int len, output logic [2:0] idx);
    lvl = bus.pwmout;
    idx = bus.key_idx;
    len = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pwmout !== lvl) break;
      len++;
    end
  endtask

  task automatic wait_for_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.pwmout === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn = 8'($urandom);
    end
    @(negedge clk);
    checks++; if (bus.pwmout !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwmout: got %0b expected 0", bus.pwmout); end
    checks++; if (bus.led !== 6'h00) begin errors++; $display("[TB] FAIL reset_led: got %h expected 00", bus.led); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid: got %0b expected 0", bus.key_valid); end
    checks++; if (bus.key_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_key_idx: got %0d expected 0", bus.key_idx); end
    bus.btn = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if ({bus.pwmout, bus.led, bus.key_valid, bus.key_idx} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got pwm=%0b led=%h kv=%0b idx=%0d expected all 0",
               bus.pwmout, bus.led, bus.key_valid, bus.key_idx);
    end
  endtask

  task automatic test_debounce();
    bit seen;
    int latency;
    // 3-cycle glitch must be filtered
    bus.btn = 8'hFE;
    repeat (3) @(negedge clk);
    bus.btn = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.led[0] === 1'b1 || bus.key_valid === 1'b1 || bus.pwmout === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL glitch_filter: got activity=1 expected 0"); end
    // Held press: led after 6 clk from the sampling edge, tone one clk later
    bus.btn = 8'hFE;
    latency = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.led[0] === 1'b1) begin
        latency = k - 1;
        break;
      end
    end
    checks++; if (latency !== 6) begin errors++; $display("[TB] FAIL debounce_latency: got %0d expected 6", latency); end
    checks++; if (bus.pwmout !== 1'b0) begin errors++; $display("[TB] FAIL pwm_before_start: got %0b expected 0", bus.pwmout); end
    @(negedge clk);
    checks++; if (bus.pwmout !== 1'b1 || bus.key_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tone_start: got pwm=%0b kv=%0b expected 1 1", bus.pwmout, bus.key_valid);
    end
  endtask

  task automatic test_single_tone();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    // Entered at the first negedge of key0's first high half
    exp_q.push_back('{1'b1, 4, 3'd0});
    exp_q.push_back('{1'b0, 4, 3'd0});
    exp_q.push_back('{1'b1, 4, 3'd0});
    exp_q.push_back('{1'b0, 4, 3'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL single_tone_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
  endtask

  task automatic test_switch();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    // Key2 pressed at the start of a key0 high half: debounce completes
    // inside the following low half, which must still run its full 4 clk.
    bus.btn = 8'hFA;
    exp_q.push_back('{1'b1, 4, 3'd0});
    exp_q.push_back('{1'b0, 4, 3'd0});
    exp_q.push_back('{1'b1, 16, 3'd2});
    exp_q.push_back('{1'b0, 16, 3'd2});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL switch_up_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    // Release key2 at the start of a 16-clk half: key0 takes over at its end
    bus.btn = 8'hFE;
    exp_q.push_back('{1'b1, 16, 3'd2});
    exp_q.push_back('{1'b0, 4, 3'd0});
    exp_q.push_back('{1'b1, 4, 3'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL switch_down_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
  endtask

  task automatic test_stop();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    bit moved;
    // Released at the start of a low half: release is accepted during the
    // next high half, which completes before the tone stops.
    bus.btn = 8'hFF;
    exp_q.push_back('{1'b0, 4, 3'd0});
    exp_q.push_back('{1'b1, 4, 3'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL stop_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    checks++; if (bus.pwmout !== 1'b0 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_edge: got pwm=%0b kv=%0b expected 0 0", bus.pwmout, bus.key_valid);
    end
    checks++; if (bus.key_idx !== 3'd0) begin errors++; $display("[TB] FAIL stop_idx_hold: got %0d expected 0", bus.key_idx); end
    moved = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.pwmout !== 1'b0 || bus.key_valid !== 1'b0) moved = 1'b1;
    end
    checks++; if (moved !== 1'b0) begin errors++; $display("[TB] FAIL stop_stays_idle: got activity=1 expected 0"); end
  endtask

  task automatic test_enable();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    bit ok;
    bus.btn = 8'hFD;
    wait_for_high(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL enable_key1_start: got timeout expected tone"); end
    // enable drops at the start of a high half: that half completes, then stop
    bus.enable = 1'b0;
    exp_q.push_back('{1'b1, 8, 3'd1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL enable_stop_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL enable_stop_kv: got %0b expected 0", bus.key_valid); end
    repeat (5) @(negedge clk);
    checks++; if (bus.led !== 6'h02 || bus.pwmout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_led_kept: got led=%h pwm=%0b expected led=02 pwm=0", bus.led, bus.pwmout);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.pwmout !== 1'b1 || bus.key_valid !== 1'b1 || bus.key_idx !== 3'd1) begin
      errors++;
      $display("[TB] FAIL enable_restart: got pwm=%0b kv=%0b idx=%0d expected 1 1 1",
               bus.pwmout, bus.key_valid, bus.key_idx);
    end
    exp_q.push_back('{1'b1, 8, 3'd1});
    exp_q.push_back('{1'b0, 8, 3'd1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL enable_restart_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    bus.btn = 8'hFF;
    repeat (40) @(negedge clk);
    checks++; if (bus.key_valid !== 1'b0 || bus.led !== 6'h00) begin
      errors++;
      $display("[TB] FAIL enable_cleanup: got kv=%0b led=%h expected 0 00", bus.key_valid, bus.led);
    end
  endtask

  task automatic test_long_tone();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    bit ok;
    bus.btn = 8'hF7;
    wait_for_high(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL key3_start: got timeout expected tone"); end
    checks++; if (bus.led !== 6'h08) begin errors++; $display("[TB] FAIL key3_led: got %h expected 08", bus.led); end
    exp_q.push_back('{1'b1, 32, 3'd3});
    exp_q.push_back('{1'b0, 32, 3'd3});
    exp_q.push_back('{1'b1, 32, 3'd3});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL key3_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    bus.btn = 8'hFF;
    repeat (80) @(negedge clk);
    checks++; if (bus.key_valid !== 1'b0 || bus.pwmout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL key3_cleanup: got kv=%0b pwm=%0b expected 0 0", bus.key_valid, bus.pwmout);
    end
  endtask

  task automatic test_async_reset();
    half_t e;
    logic lvl;
    int len;
    logic [2:0] idx;
    bit ok;
    bit early;
    int latency;
    bus.btn = 8'hFE;
    wait_for_high(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL async_pre_tone: got timeout expected tone"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pwmout !== 1'b0 || bus.key_valid !== 1'b0 || bus.led !== 6'h00) begin
      errors++;
      $display("[TB] FAIL async_reset_clear: got pwm=%0b kv=%0b led=%h expected 0 0 00",
               bus.pwmout, bus.key_valid, bus.led);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    latency = -1;
    early = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.pwmout === 1'b1) early = 1'b1;
      if (bus.led[0] === 1'b1) begin
        latency = k - 1;
        break;
      end
    end
    checks++; if (latency !== 6 || early !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_redebounce: got latency=%0d early_tone=%0b expected 6 0", latency, early);
    end
    @(negedge clk);
    exp_q.push_back('{1'b1, 4, 3'd0});
    exp_q.push_back('{1'b0, 4, 3'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_half(lvl, len, idx);
      checks++;
      if (lvl !== e.lvl || len !== e.len || idx !== e.idx) begin
        errors++;
        $display("[TB] FAIL async_restart_half: got lvl=%0b len=%0d idx=%0d expected lvl=%0b len=%0d idx=%0d",
                 lvl, len, idx, e.lvl, e.len, e.idx);
      end
    end
    bus.btn = 8'hFF;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.btn    = 8'hFF;
    bus.enable = 1'b1;
    test_reset();
    test_debounce();
    test_single_tone();
    test_switch();
    test_stop();
    test_enable();
    test_long_tone();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
